// File: rtl/pm_pkg.sv
// rtl/pm_pkg.sv - shared constants and width types for the pseudo-Mersenne reducer
package pm_pkg;

    localparam int W     = 256;
    localparam int C_W   = 33;
    localparam int TAG_W = 8;

    localparam logic [C_W-1:0] C = 33'h1000003D1;

    // p = 2^W - C, formed as the W-bit two's complement negation of C
    localparam logic [W-1:0] P_MOD = {W{1'b0}} - W'(C);

    typedef logic [2*W-1:0]   prod_t;
    typedef logic [W+C_W:0]   fold1_t;
    typedef logic [W:0]       fold2_t;
    typedef logic [W-1:0]     res_t;

endpackage

// File: rtl/pm_fold.sv
// rtl/pm_fold.sv - one pseudo-Mersenne fold step: sum = hi * C + lo
module pm_fold #(
    parameter int W   = 256,
    parameter int HW  = 256,
    parameter int C_W = 33,
    parameter logic [C_W-1:0] C = 33'h1000003D1,
    parameter int OW  = ((HW + C_W) > W ? (HW + C_W) : W) + 1
) (
    input  logic [HW-1:0] hi,
    input  logic [W-1:0]  lo,
    output logic [OW-1:0] sum
);

    // The caller sizes OW so the true result always fits; truncation never drops value bits.
    always_comb begin
        sum = OW'(hi) * OW'(C) + OW'(lo);
    end

endmodule

// File: rtl/pm_reduce.sv
// rtl/pm_reduce.sv - 3-stage valid/ready reducer of a 2W-bit product modulo 2^W - C
module pm_reduce #(
    parameter int W     = pm_pkg::W,
    parameter int C_W   = pm_pkg::C_W,
    parameter logic [C_W-1:0] C = pm_pkg::C,
    parameter int TAG_W = pm_pkg::TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   prod,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     res,
    output logic [TAG_W-1:0] out_tag
);

    localparam int A_W = W + C_W + 1;
    localparam int B_W = W + 1;
    localparam logic [W-1:0]   P_MOD = {W{1'b0}} - W'(C);
    localparam logic [B_W-1:0] P_EXT = {1'b0, P_MOD};

    logic             stall;
    logic [A_W-1:0]   fold1_sum;
    logic [B_W-1:0]   fold2_sum;
    logic [W-1:0]     final_res;

    logic             s1_valid;
    logic [A_W-1:0]   s1_a;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [B_W-1:0]   s2_b;
    logic [TAG_W-1:0] s2_tag;

    // Global stall: only a held result at the output can freeze the pipe.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    pm_fold #(
        .W   (W),
        .HW  (W),
        .C_W (C_W),
        .C   (C),
        .OW  (A_W)
    ) u_fold1 (
        .hi  (prod[2*W-1:W]),
        .lo  (prod[W-1:0]),
        .sum (fold1_sum)
    );

    pm_fold #(
        .W   (W),
        .HW  (C_W + 1),
        .C_W (C_W),
        .C   (C),
        .OW  (B_W)
    ) u_fold2 (
        .hi  (s1_a[A_W-1:W]),
        .lo  (s1_a[W-1:0]),
        .sum (fold2_sum)
    );

    // After two folds B < 2p, so one conditional subtraction gives the canonical residue.
    always_comb begin
        final_res = s2_b[W-1:0];
        if (s2_b >= P_EXT) begin
            final_res = W'(s2_b - P_EXT);
        end
    end

    // Stage registers: all advance together unless the output is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_b      <= '0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            res       <= '0;
            out_tag   <= '0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_a      <= fold1_sum;
            s1_tag    <= in_tag;
            s2_valid  <= s1_valid;
            s2_b      <= fold2_sum;
            s2_tag    <= s1_tag;
            out_valid <= s2_valid;
            res       <= final_res;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_pm_reduce.sv
// tb/tb_pm_reduce.sv - scoreboard bench for pm_reduce
module tb_pm_reduce;
    import pm_pkg::*;

    localparam logic [255:0] P_H = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef struct {
        logic [255:0] res;
        logic [7:0]   tag;
        int           cyc;
    } exp_t;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] prod;
    logic [7:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] res;
    logic [7:0]   out_tag;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic chk_lat  = 1'b1;
    logic bp_mode  = 1'b0;

    pm_reduce dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .out_tag   (out_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input logic ok, input string name,
                                input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic logic [255:0] model(input logic [511:0] x);
        logic [511:0] pw;
        logic [511:0] r;
        pw = {256'd0, P_H};
        r  = x % pw;
        return r[255:0];
    endfunction

    // Monitor: handshake invariant, stall stability, and in-order scoreboard compare.
    initial begin
        logic         prev_stall;
        logic         prev_reset;
        logic [255:0] prev_res;
        logic [7:0]   prev_tag;
        exp_t         e;
        prev_stall = 1'b0;
        prev_reset = 1'b1;
        prev_res   = '0;
        prev_tag   = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb.delete();
            end else begin
                chk(in_ready == !(out_valid && !out_ready), "in_ready_vs_stall",
                    256'(in_ready), 256'(!(out_valid && !out_ready)));
                if (prev_stall && !prev_reset) begin
                    chk(out_valid && res == prev_res && out_tag == prev_tag, "hold_while_stalled",
                        res, prev_res);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_output", res, 256'd0);
                    end else begin
                        e = sb.pop_front();
                        chk(res == e.res, "res", res, e.res);
                        chk(out_tag == e.tag, "out_tag", 256'(out_tag), 256'(e.tag));
                        if (chk_lat) begin
                            chk(cyc - e.cyc == 3, "latency", 256'(cyc - e.cyc), 256'd3);
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_reset = reset;
            prev_res   = res;
            prev_tag   = out_tag;
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [511:0] p, input logic [7:0] t, input logic [255:0] e);
        int  n;
        logic acc;
        in_valid = 1'b1;
        prod     = p;
        in_tag   = t;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 200) begin
            @(negedge clock);
            if (in_ready && !reset) begin
                sb.push_back('{res: e, tag: t, cyc: cyc});
                acc = 1'b1;
            end
            n++;
        end
        if (!acc) chk(1'b0, "accept_timeout", 256'(n), 256'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk(sb.size() == 0, "drain", 256'(sb.size()), 256'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [511:0] p;
        logic [511:0] a;
        logic [511:0] q;
        reset     = 1'b1;
        in_valid  = 1'b0;
        prod      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk(out_valid == 1'b0, "reset_out_valid", 256'(out_valid), 256'd0);
        chk(in_ready == 1'b1, "reset_in_ready", 256'(in_ready), 256'd1);
        chk(res == 256'd0, "reset_res", res, 256'd0);
        chk(out_tag == 8'd0, "reset_out_tag", 256'(out_tag), 256'd0);
        @(posedge clock);
        #1;

        // Directed values with hand-derived results, each isolated by idle gaps.
        send(512'd0, 8'h11, 256'd0);
        idle(4);
        send({256'd0, P_H}, 8'h22, 256'd0);
        idle(4);
        send({256'd0, P_H - 256'd1}, 8'h33, P_H - 256'd1);
        idle(4);
        p = 512'd1 << 256;
        send(p, 8'h44, 256'h1000003D1);
        idle(4);
        send({256'd0, {256{1'b1}}}, 8'h55, 256'h1000003D0);
        idle(4);
        send({512{1'b1}}, 8'h66, 256'h1000007A2000E90A0);
        idle(4);
        a = {256'd0, P_H - 256'd1};
        q = a * a;
        send(q, 8'h77, 256'd1);
        drain();

        // Back-to-back stream: random products with occasional near-p squares.
        for (int i = 0; i < 1000; i++) begin
            if (i % 97 == 0) begin
                a = {256'd0, P_H - 256'(i + 1)};
                p = a * a;
            end else begin
                for (int k = 0; k < 16; k++) p[k*32 +: 32] = $urandom();
            end
            send(p, 8'(i), model(p));
        end
        drain();

        // Random backpressure and random input gaps.
        chk_lat = 1'b0;
        bp_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < 16; k++) p[k*32 +: 32] = $urandom();
            send(p, 8'(i + 8'h80), model(p));
            idle($urandom_range(0, 2));
        end
        bp_mode = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        drain();
        chk_lat = 1'b1;

        // Reset with products in flight, a third one presented alongside reset.
        send(512'd5, 8'hA1, 256'd5);
        send(512'd6, 8'hA2, 256'd6);
        in_valid = 1'b1;
        prod     = 512'd7;
        in_tag   = 8'hA3;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk(out_valid == 1'b0, "post_reset_out_valid", 256'(out_valid), 256'd0);
        chk(res == 256'd0, "post_reset_res", res, 256'd0);
        chk(out_tag == 8'd0, "post_reset_out_tag", 256'(out_tag), 256'd0);
        @(posedge clock);
        #1;
        idle(10);
        p = (512'd1 << 256) + 512'd9;
        send(p, 8'hB4, 256'h1000003DA);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
